// File: rtl/seq_comparator_if.sv
// seq_comparator_if
//   Handshake and operand/result bundle for seq_comparator.
//   master : producer/consumer side (drives operands, in_valid, out_ready)
//   slave  : comparator side (drives in_ready, out_valid, eq, gt, lt)
// Signals
//   in_valid / in_ready   operand handshake
//   a, b [WIDTH]          operands
//   is_signed             1 = two's-complement compare, 0 = unsigned
//   out_valid / out_ready result handshake
//   eq, gt, lt            compare result
interface seq_comparator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, eq, gt, lt
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, eq, gt, lt
  );
endinterface

// File: rtl/seq_comparator.sv
// seq_comparator
//   Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared
//   SLICE bits per clock, MSB slice first, producing eq/gt/lt.
//   Unsigned and two's-complement compares are supported.
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   bus      slave modport of seq_comparator_if (operand/result handshakes)
// Parameters
//   WIDTH    operand width
//   SLICE    bits compared per cycle (WIDTH must be a multiple of SLICE)
// Build option
//   CMP_EARLY_EXIT_EN : when defined, RUN ends at the first differing slice
//                       instead of always walking all NSLICE slices.
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int SLICE = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  seq_comparator_if.slave   bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_slice_check
    $error("seq_comparator: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Extract slice i of v. In signed mode the operand MSB is inverted in the
  // top slice: this maps two's-complement order onto unsigned order, so the
  // same unsigned slice compare serves both modes.
  function automatic logic [SLICE-1:0] slice_at(
    input logic [WIDTH-1:0] v,
    input logic [IDX_W-1:0] i,
    input logic             sgn
  );
    logic [SLICE-1:0] s;
    s = SLICE'(v >> (int'(i) * SLICE));
    if (sgn && (i == IDX_TOP)) begin
      s[SLICE-1] = ~s[SLICE-1];
    end
    return s;
  endfunction

  // Control state (reset)
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  // Datapath state (no reset; always written before use)
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             eq_r_q, eq_r_d;
  logic             gt_r_q, gt_r_d;

  // Combinational slice step
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic             step_eq;
  logic             step_gt;
  logic             finish;

  always_comb begin
    slice_a = slice_at(a_q, idx_q, sgn_q);
    slice_b = slice_at(b_q, idx_q, sgn_q);
    // Once a higher slice has decided (eq_r=0) the running result is frozen.
    if (eq_r_q) begin
      step_eq = (slice_a == slice_b);
      step_gt = (slice_a >  slice_b);
    end else begin
      step_eq = eq_r_q;
      step_gt = gt_r_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    eq_r_d  = eq_r_q;
    gt_r_d  = gt_r_q;
    finish  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sgn_d   = bus.is_signed;
          eq_r_d  = 1'b1;
          gt_r_d  = 1'b0;
          idx_d   = IDX_TOP;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        eq_r_d = step_eq;
        gt_r_d = step_gt;
`ifdef CMP_EARLY_EXIT_EN
        // Leave as soon as this slice decides the outcome.
        finish = (idx_q == '0) || (eq_r_q && !step_eq);
`else
        finish = (idx_q == '0);
`endif
        if (finish) begin
          eq_d    = step_eq;
          gt_d    = step_gt;
          lt_d    = !step_eq && !step_gt;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      S_DONE: begin
        // Result stays on eq/gt/lt until the next operand accept.
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_TOP;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  always_ff @(posedge clock) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sgn_q  <= sgn_d;
    eq_r_q <= eq_r_d;
    gt_r_q <= gt_r_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;

endmodule
